// File: rtl/regfile_write_sequencer.sv
// Arbitrates two writers onto the register bank's shared DIN bus and sequences
// each write as setup -> strobe -> hold so DIN is stable whenever a W line is high.
module regfile_write_sequencer #(
  parameter int WIDTH         = 16,
  parameter int NREGS         = 8,
  parameter int ADDR_W        = 3,
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [WIDTH-1:0]  data0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [WIDTH-1:0]  data1,
  output logic [1:0]        gnt,
  output logic [1:0]        done,
  output logic [WIDTH-1:0]  bus_din,
  output logic [NREGS-1:0]  w_en,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);

  state_t             state_reg, state_next;
  logic [3:0]         cnt_reg, cnt_next;
  logic               last_reg, last_next;   // 1 when requester 1 was served last
  logic [ADDR_W-1:0]  addr_reg, addr_next;
  logic [WIDTH-1:0]   din_reg, din_next;
  logic [1:0]         gnt_reg, gnt_next;
  logic [1:0]         done_reg, done_next;
  logic [NREGS-1:0]   w_en_reg, w_en_next;
  logic               busy_reg, busy_next;
  logic [NREGS-1:0]   addr_dec;
  logic               win;
  logic               cnt_zero;

  assign cnt_zero = (cnt_reg == 4'd0);

  // On a tie the requester not served last wins; otherwise the sole requester.
  assign win = (req == 2'b11) ? ~last_reg : req[1];

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_dec
      assign addr_dec[gi] = (addr_reg == ADDR_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      last_reg  <= 1'b1;
      addr_reg  <= '0;
      din_reg   <= '0;
      gnt_reg   <= 2'b00;
      done_reg  <= 2'b00;
      w_en_reg  <= '0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      last_reg  <= last_next;
      addr_reg  <= addr_next;
      din_reg   <= din_next;
      gnt_reg   <= gnt_next;
      done_reg  <= done_next;
      w_en_reg  <= w_en_next;
      busy_reg  <= busy_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req != 2'b00) state_next = SETUP;
      SETUP:   if (cnt_zero) state_next = STROBE;
      STROBE:  if (cnt_zero) state_next = HOLD;
      HOLD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Computes the next value of every output flop so no input reaches a port combinationally.
  always_comb begin
    cnt_next  = cnt_reg;
    last_next = last_reg;
    addr_next = addr_reg;
    din_next  = din_reg;
    gnt_next  = gnt_reg;
    done_next = 2'b00;
    w_en_next = '0;
    busy_next = busy_reg;
    case (state_reg)
      IDLE: begin
        if (req != 2'b00) begin
          gnt_next  = win ? 2'b10 : 2'b01;
          last_next = win;
          addr_next = win ? addr1 : addr0;
          din_next  = win ? data1 : data0;
          cnt_next  = SETUP_LOAD;
          busy_next = 1'b1;
        end
      end
      SETUP: begin
        if (cnt_zero) begin
          cnt_next  = STROBE_LOAD;
          w_en_next = addr_dec;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      STROBE: begin
        if (cnt_zero) begin
          done_next = gnt_reg;
        end else begin
          cnt_next  = cnt_reg - 4'd1;
          w_en_next = addr_dec;
        end
      end
      HOLD: begin
        gnt_next  = 2'b00;
        busy_next = 1'b0;
      end
      default: begin
        gnt_next  = 2'b00;
        busy_next = 1'b0;
      end
    endcase
  end

  assign gnt     = gnt_reg;
  assign done    = done_reg;
  assign bus_din = din_reg;
  assign w_en    = w_en_reg;
  assign busy    = busy_reg;

endmodule
